schmidl_cox_sync_ctrl: RTL and testbench

//  Sequencer for the Schmidl-Cox packet-detect chain: consumes the per-sample

---
 rtl/schmidl_cox_sync_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_schmidl_cox_sync_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schmidl_cox_sync_ctrl.sv
// Schmidl-Cox packet-detect sequencer: turns the plateau/phase stream into
// per-sample frame control flags plus a latched CFO phase increment.
module schmidl_cox_sync_ctrl #(
    parameter int BASE        = 0,
    parameter int PHASE_SHIFT = 5,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [15:0] frame_cnt,
    output logic        locked
);

    typedef enum logic [2:0] {
        S_SEARCH,
        S_CONFIRM,
        S_WAIT_FIRST,
        S_FRAME,
        S_HOLDOFF
    } state_t;

    localparam logic [7:0] ADDR_DELAY   = 8'(BASE);
    localparam logic [7:0] ADDR_SYM_LEN = 8'(BASE + 1);
    localparam logic [7:0] ADDR_NSYMS   = 8'(BASE + 2);
    localparam logic [7:0] ADDR_HOLDOFF = 8'(BASE + 3);
    localparam logic [7:0] ADDR_CTRL    = 8'(BASE + 4);
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Live settings registers
    logic [CNT_W-1:0] r_delay, r_sym_len, r_num_syms, r_holdoff, r_min_plat;
    logic             r_enable;

    // Per-packet snapshot of the settings (zero lengths already mapped to 1)
    logic [CNT_W-1:0] r_a_delay, r_a_sym_len, r_a_num_syms, r_a_holdoff, r_a_min_plat;

    // FSM state, counters and phase tracking
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_pcnt, r_cnt, r_samp, r_sym;
    logic [CNT_W-1:0] w_pcnt_nxt, w_cnt_nxt, w_samp_nxt, w_sym_nxt;
    logic [15:0]      r_phase, r_phase_inc, r_frame_cnt;
    logic [15:0]      w_phase_nxt, w_phase_inc_nxt, w_frame_cnt_nxt;
    logic             w_snapshot;

    // Per-beat control flags and the frame position of the current beat
    logic             w_sof, w_sos, w_eob, w_active, w_frame_beat;
    logic [CNT_W-1:0] w_pos_samp, w_pos_sym;

    logic             w_beat, w_flag;
    logic [15:0]      w_phase_shifted;
    logic             w_unused;

    assign i_tready        = ~o_tvalid | o_tready;
    assign w_beat          = i_tvalid & i_tready;
    assign w_flag          = i_tdata[31];
    assign w_phase_shifted = 16'($signed(r_phase) >>> PHASE_SHIFT);
    assign locked          = (r_state == S_WAIT_FIRST) || (r_state == S_FRAME);
    assign frame_cnt       = r_frame_cnt;
    assign w_unused        = &{1'b0, i_tdata[30:16], set_data[30:CNT_W]};

    // Settings bus writes; these survive a synchronous clear
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_delay    <= '0;
            r_sym_len  <= CNT_W'(80);
            r_num_syms <= ONE;
            r_holdoff  <= '0;
            r_min_plat <= CNT_W'(16);
            r_enable   <= 1'b0;
        end else if (set_stb) begin
            case (set_addr)
                ADDR_DELAY:   r_delay    <= set_data[CNT_W-1:0];
                ADDR_SYM_LEN: r_sym_len  <= set_data[CNT_W-1:0];
                ADDR_NSYMS:   r_num_syms <= set_data[CNT_W-1:0];
                ADDR_HOLDOFF: r_holdoff  <= set_data[CNT_W-1:0];
                ADDR_CTRL: begin
                    r_min_plat <= set_data[CNT_W-1:0];
                    r_enable   <= set_data[31];
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: disable aborts at once, otherwise the FSM moves only on beats
    always_comb begin
        w_state_nxt     = r_state;
        w_pcnt_nxt      = r_pcnt;
        w_cnt_nxt       = r_cnt;
        w_samp_nxt      = r_samp;
        w_sym_nxt       = r_sym;
        w_phase_nxt     = r_phase;
        w_phase_inc_nxt = r_phase_inc;
        w_frame_cnt_nxt = r_frame_cnt;
        w_snapshot      = 1'b0;
        w_sof           = 1'b0;
        w_sos           = 1'b0;
        w_eob           = 1'b0;
        w_active        = 1'b0;
        w_frame_beat    = 1'b0;
        w_pos_samp      = r_samp;
        w_pos_sym       = r_sym;
        if (!r_enable) begin
            w_state_nxt = S_SEARCH;
            w_pcnt_nxt  = '0;
            w_cnt_nxt   = '0;
            w_samp_nxt  = '0;
            w_sym_nxt   = '0;
        end else if (w_beat) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_flag) begin
                        w_state_nxt = S_CONFIRM;
                        w_pcnt_nxt  = ONE;
                        w_phase_nxt = i_tdata[15:0];
                        w_snapshot  = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (w_flag) begin
                        if (r_pcnt != '1) w_pcnt_nxt = r_pcnt + ONE;
                        w_phase_nxt = i_tdata[15:0];
                    end else if (r_pcnt >= r_a_min_plat) begin
                        w_phase_inc_nxt = w_phase_shifted;
                        if (r_a_delay == '0) begin
                            w_sof        = 1'b1;
                            w_frame_beat = 1'b1;
                            w_pos_samp   = '0;
                            w_pos_sym    = '0;
                        end else begin
                            w_state_nxt = S_WAIT_FIRST;
                            w_cnt_nxt   = ONE;
                        end
                    end else begin
                        w_state_nxt = S_SEARCH;
                        w_pcnt_nxt  = '0;
                    end
                end
                S_WAIT_FIRST: begin
                    if (r_cnt == r_a_delay) begin
                        w_sof        = 1'b1;
                        w_frame_beat = 1'b1;
                        w_pos_samp   = '0;
                        w_pos_sym    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                S_FRAME: w_frame_beat = 1'b1;
                S_HOLDOFF: begin
                    if (r_cnt == r_a_holdoff) begin
                        w_state_nxt = S_SEARCH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                default: w_state_nxt = S_SEARCH;
            endcase
            if (w_frame_beat) begin
                w_active    = 1'b1;
                w_sos       = (w_pos_samp == '0);
                w_state_nxt = S_FRAME;
                w_cnt_nxt   = '0;
                if (w_pos_samp == r_a_sym_len - ONE) begin
                    w_samp_nxt = '0;
                    if (w_pos_sym == r_a_num_syms - ONE) begin
                        w_eob           = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                        w_sym_nxt       = '0;
                        if (r_a_holdoff == '0) begin
                            w_state_nxt = S_SEARCH;
                        end else begin
                            w_state_nxt = S_HOLDOFF;
                            w_cnt_nxt   = ONE;
                        end
                    end else begin
                        w_sym_nxt = w_pos_sym + ONE;
                    end
                end else begin
                    w_samp_nxt = w_pos_samp + ONE;
                    w_sym_nxt  = w_pos_sym;
                end
            end
        end
    end

    // State, counter and phase registers; clear returns them to their reset values
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_SEARCH;
            r_pcnt       <= '0;
            r_cnt        <= '0;
            r_samp       <= '0;
            r_sym        <= '0;
            r_phase      <= '0;
            r_phase_inc  <= '0;
            r_frame_cnt  <= '0;
            r_a_delay    <= '0;
            r_a_sym_len  <= ONE;
            r_a_num_syms <= ONE;
            r_a_holdoff  <= '0;
            r_a_min_plat <= ONE;
        end else if (clear) begin
            r_state     <= S_SEARCH;
            r_pcnt      <= '0;
            r_cnt       <= '0;
            r_samp      <= '0;
            r_sym       <= '0;
            r_phase     <= '0;
            r_phase_inc <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_samp      <= w_samp_nxt;
            r_sym       <= w_sym_nxt;
            r_phase     <= w_phase_nxt;
            r_phase_inc <= w_phase_inc_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            if (w_snapshot) begin
                r_a_delay    <= r_delay;
                r_a_sym_len  <= (r_sym_len == '0) ? ONE : r_sym_len;
                r_a_num_syms <= (r_num_syms == '0) ? ONE : r_num_syms;
                r_a_holdoff  <= r_holdoff;
                r_a_min_plat <= (r_min_plat == '0) ? ONE : r_min_plat;
            end
        end
    end

    // Single output stage: load on a beat, release once downstream takes it
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else if (clear) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else if (w_beat) begin
            o_tvalid <= 1'b1;
            o_tdata  <= {w_sof, w_sos, w_eob, w_active, 12'h000, w_phase_inc_nxt};
            o_tlast  <= i_tlast;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_schmidl_cox_sync_ctrl.sv
// Self-checking bench for schmidl_cox_sync_ctrl: expected output words are
// queued as beats are accepted and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_schmidl_cox_sync_ctrl;

    logic        clk = 1'b0;
    logic        aresetn, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
    logic [15:0] frame_cnt;
    logic        locked;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_word;
    logic [15:0] exp_pinc = 16'h0000;
    int          exp_frames = 0;
    bit          stall_mode = 1'b0;
    bit          hold_ready = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;

    schmidl_cox_sync_ctrl dut (
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .frame_cnt(frame_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    // Downstream ready: always 1, forced 0, or 50% random while stalling
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) o_tready = 1'b0;
            else if (stall_mode) o_tready = 1'($urandom_range(0, 1));
            else o_tready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each transfer and checks stalled data holds
    always @(negedge clk) begin
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!o_tvalid || o_tdata !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h",
                             o_tvalid, o_tdata, prev_data);
                end
            end
            if (o_tvalid && o_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got %h, required no output", {o_tlast, o_tdata});
                end else begin
                    exp_word = exp_q.pop_front();
                    if ({o_tlast, o_tdata} !== exp_word) begin
                        errors++;
                        $display("[TB] FAIL out_word: got %h, required %h", {o_tlast, o_tdata}, exp_word);
                    end
                end
            end
            prev_hold = o_tvalid && !o_tready && !clear;
            prev_data = o_tdata;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk(input bit sof, input bit sos, input bit eob,
                                       input bit act, input logic [15:0] pinc);
        return {sof, sos, eob, act, 12'h000, pinc};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        #2;
        set_stb = 1'b0;
    endtask

    task automatic send_beat(input bit flag, input logic [15:0] phase, input logic [31:0] expw);
        int n;
        bit lst;
        if (stall_mode) idle($urandom_range(0, 2));
        lst      = 1'($urandom_range(0, 1));
        i_tdata  = {flag, 15'($urandom), phase};
        i_tlast  = lst;
        i_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_tready && n < 200);
        if (!i_tready) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept: i_tready=0 after %0d cycles, required 1", n);
        end else begin
            exp_q.push_back({lst, expw});
        end
        @(posedge clk);
        #2;
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Plateau, falling beat, then nsend beats of wait+frame (0 = whole frame)
    task automatic run_frame(input logic [15:0] phase, input int nplat, input int delay,
                             input int slen, input int nsym, input int nsend,
                             input logic [15:0] new_pinc);
        int total, lim;
        for (int i = 0; i < nplat; i++) send_beat(1'b1, phase, mk(0, 0, 0, 0, exp_pinc));
        exp_pinc = new_pinc;
        total = delay + slen * nsym;
        lim = (nsend == 0) ? total : nsend;
        for (int i = 0; i < lim; i++) begin
            automatic bit act = (i >= delay);
            automatic int p = i - delay;
            automatic bit flag = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            send_beat(flag, 16'($urandom),
                      mk(i == delay, act && (p % slen == 0), act && (p == slen * nsym - 1), act, exp_pinc));
            if (i == delay) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL locked_at_sof: got %0b, required 1", locked);
                end
            end
        end
        if (lim == total) exp_frames++;
    endtask

    task automatic check_frames(input string name);
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL %s frame_cnt: got %0d, required %0d", name, frame_cnt, exp_frames);
        end
    endtask

    task automatic check_unlocked(input string name);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s locked: got %0b, required 0", name, locked);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        idle(3);
        checks++;
        if ({o_tvalid, o_tlast, o_tdata, frame_cnt, locked} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%0b last=%0b data=%h frames=%0d locked=%0b, required all 0",
                     o_tvalid, o_tlast, o_tdata, frame_cnt, locked);
        end
        aresetn = 1'b1;
        idle(2);
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_valid: got %0b, required 0", o_tvalid);
        end
        check_unlocked("post_reset");
    endtask

    task automatic test_delay0();
        write_reg(8'd4, 32'h8000_0010);
        run_frame(16'h0400, 20, 0, 80, 1, 0, 16'h0020);
        drain();
        check_frames("delay0");
        check_unlocked("delay0_end");
    endtask

    task automatic test_short_plateau();
        for (int i = 0; i < 10; i++) send_beat(1'b1, 16'h1234, mk(0, 0, 0, 0, exp_pinc));
        for (int i = 0; i < 5; i++) send_beat(1'b0, 16'($urandom), mk(0, 0, 0, 0, exp_pinc));
        drain();
        check_unlocked("short_plateau");
        check_frames("short_plateau");
    endtask

    task automatic test_framing();
        write_reg(8'd0, 32'd5);
        write_reg(8'd2, 32'd3);
        write_reg(8'd3, 32'd10);
        run_frame(16'h0400, 16, 5, 80, 3, 0, 16'h0020);
        for (int i = 0; i < 10; i++) send_beat(1'b1, 16'h7000, mk(0, 0, 0, 0, exp_pinc));
        for (int i = 0; i < 15; i++) send_beat(1'b1, 16'h7000, mk(0, 0, 0, 0, exp_pinc));
        send_beat(1'b0, 16'h7000, mk(0, 0, 0, 0, exp_pinc));
        drain();
        check_frames("framing");
        check_unlocked("after_holdoff_short_plateau");
    endtask

    task automatic test_stall();
        stall_mode = 1'b1;
        run_frame(16'h0400, 16, 5, 80, 3, 0, 16'h0020);
        for (int i = 0; i < 10; i++) send_beat(1'b1, 16'h5555, mk(0, 0, 0, 0, exp_pinc));
        drain();
        stall_mode = 1'b0;
        idle(2);
        check_frames("stall");
    endtask

    task automatic test_disable();
        run_frame(16'h0400, 16, 5, 80, 3, 105, 16'h0020);
        write_reg(8'd4, 32'h0000_0010);
        idle(2);
        check_unlocked("disable");
        for (int i = 0; i < 3; i++) send_beat(1'b1, 16'($urandom), mk(0, 0, 0, 0, exp_pinc));
        drain();
        check_frames("disable");
        write_reg(8'd4, 32'h8000_0010);
    endtask

    task automatic test_clear();
        hold_ready = 1'b1;
        idle(1);
        i_tdata  = {1'b1, 15'h0000, 16'h0400};
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        @(posedge clk);
        #2;
        i_tvalid = 1'b0;
        checks++;
        if (o_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_pending_valid: got %0b, required 1", o_tvalid);
        end
        clear = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        hold_ready = 1'b0;
        exp_pinc = 16'h0000;
        exp_frames = 0;
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_drop_valid: got %0b, required 0", o_tvalid);
        end
        check_frames("clear");
        check_unlocked("clear");
        send_beat(1'b0, 16'($urandom), mk(0, 0, 0, 0, 16'h0000));
        drain();
    endtask

    task automatic test_negative_phase();
        run_frame(16'hF800, 16, 5, 80, 3, 0, 16'hFFC0);
        for (int i = 0; i < 10; i++) send_beat(1'b1, 16'h0100, mk(0, 0, 0, 0, exp_pinc));
        drain();
        check_frames("negative_phase");
    endtask

    task automatic test_async_reset();
        run_frame(16'h0400, 16, 5, 80, 3, 25, 16'h0020);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({o_tvalid, o_tlast, o_tdata, frame_cnt, locked} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%0b last=%0b data=%h frames=%0d locked=%0b, required all 0",
                     o_tvalid, o_tlast, o_tdata, frame_cnt, locked);
        end
        exp_q.delete();
        idle(2);
        aresetn = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_delay0();
        test_short_plateau();
        test_framing();
        test_stall();
        test_disable();
        test_clear();
        test_negative_phase();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
